gcd_ops_fifo: RTL and testbench
===============================

GCD_OPS_FIFO -- requirements
Module: gcd_ops_fifo

Interface
REQ-001 Parameter WL, default 8, SHALL set the width in bits of each operand.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of operand-pair entries and SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_b  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_val  input  1  SHALL mark that the producer presents a valid operand pair.
REQ-006 in_rdy  output  1  SHALL mark that the FIFO can accept a pair this cycle.
REQ-007 in_A, in_B  input  WL each  SHALL be the producer operands.
REQ-008 ops_val  output  1  SHALL mark that a buffered pair is presented to the GCD unit.
REQ-009 ops_rdy  input  1  SHALL mark that the GCD unit accepts the presented pair.
REQ-010 ops_A, ops_B  output  WL each  SHALL be the head-of-queue operands.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL be the current occupancy.

Function
REQ-012 A push SHALL occur on a rising edge where in_val and in_rdy are both 1.
REQ-013 A pop SHALL occur on a rising edge where ops_val and ops_rdy are both 1.
REQ-014 in_rdy SHALL equal (count != DEPTH), with no combinational path from ops_rdy.
REQ-015 ops_val SHALL equal (count != 0), with no combinational path from in_val.
REQ-016 ops_A and ops_B SHALL be driven from storage at the read pointer.
REQ-017 ops_A and ops_B SHALL remain stable while ops_val=1 and ops_rdy=0.
REQ-018 Pairs SHALL be delivered in strict arrival order with A and B kept paired.
REQ-019 Latency SHALL be one cycle: a pair pushed at edge N is presented with ops_val=1 after edge N; there is no empty bypass.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-021 On a simultaneous push and pop with 0<count<DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When empty, a push SHALL increment count; no pop is possible.
REQ-023 When full, a pop SHALL decrement count; no push is possible.
REQ-024 When full, in_rdy=0 SHALL hold even if ops_rdy=1 in the same cycle.
REQ-025 in_A and in_B SHALL be ignored on any cycle without a push.

Reset
REQ-026 While rst_b=0, count, both pointers, ops_val SHALL be 0 and in_rdy SHALL be 1, independent of clk.
REQ-027 A reset mid-operation SHALL discard all buffered pairs.
REQ-028 Storage contents need not be reset.
REQ-029 ops_A and ops_B SHALL be don't-care while ops_val=0.
REQ-030 After rst_b deasserts, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-031 When macro GCD_OPS_ZERO_DROP_EN is defined, a push with in_A==0 and in_B==0 SHALL complete the handshake but SHALL NOT be stored.
REQ-032 With GCD_OPS_ZERO_DROP_EN defined, count and the pointers SHALL be unchanged by such a push.
REQ-033 Without GCD_OPS_ZERO_DROP_EN, an all-zero pair SHALL be stored like any other pair.
REQ-034 The port list SHALL be identical in both builds.

Structure
REQ-035 Shared package gcd_pkg SHALL hold the operand-pair struct typedef, parameterised by WL through a package constant.
REQ-036 gcd_pkg SHALL hold the default WL and DEPTH constants, shared with the GCD control and datapath.
REQ-037 Storage SHALL be a sub-module gcd_ops_mem: a DEPTH x pair register file with one write port and one asynchronous read port.
REQ-038 Pointer, count and handshake logic SHALL reside in gcd_ops_fifo.

Verification
REQ-039 Single pair: after reset, push (A=48, B=18) -> ops_val=1 one cycle later with ops_A=48, ops_B=18, count=1; ops_rdy=1 -> count=0, ops_val=0.
REQ-040 Fill and drain: hold ops_rdy=0 and push 4 pairs (1,1)..(4,4) with DEPTH=4 -> count=4, in_rdy=0, a fifth push is not accepted; drain -> pairs come out in order 1..4.
REQ-041 Back-pressure: ops_rdy=0 for 5 cycles with head (21,14) -> ops_A and ops_B stay stable throughout, count unchanged.
REQ-042 Simultaneous push/pop: at count=2, push and pop on the same edge -> count stays 2; after 10 such cycles the pointers have wrapped with no data loss.
REQ-043 Async reset: at count=3, pulse rst_b low between edges -> ops_val=0 and count=0 immediately, before the next edge.
REQ-044 Zero drop: push (0,0) then (9,6) -> with GCD_OPS_ZERO_DROP_EN the first pair out is (9,6) with count peaking at 1; without it the pairs come out as (0,0) then (9,6).

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants and operand-pair type for the GCD control, datapath and operand FIFO.
package gcd_pkg;

  localparam int GCD_WL    = 8;
  localparam int GCD_DEPTH = 4;

  typedef struct packed {
    logic [GCD_WL-1:0] a;
    logic [GCD_WL-1:0] b;
  } ops_pair_t;

endpackage

// File: rtl/gcd_ops_mem.sv
// DEPTH-entry register file: one synchronous write port, one asynchronous read port.
module gcd_ops_mem #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  // Contents are deliberately left unreset; occupancy tracking lives in the FIFO.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gcd_ops_fifo.sv
// Operand-pair FIFO feeding the GCD unit; registered-only ready/valid, no empty bypass.
// Define GCD_OPS_ZERO_DROP_EN to accept-but-discard all-zero operand pairs.
module gcd_ops_fifo
  import gcd_pkg::*;
#(
  parameter  int WL    = GCD_WL,
  parameter  int DEPTH = GCD_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [WL-1:0] in_A,
  input  logic [WL-1:0] in_B,
  output logic          ops_val,
  input  logic          ops_rdy,
  output logic [WL-1:0] ops_A,
  output logic [WL-1:0] ops_B,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [WL-1:0] a;
    logic [WL-1:0] b;
  } pair_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, store, drop;
  pair_t         wdata, rdata;

  // Both flags come only from registered count, so no ready/valid feedthrough.
  assign in_rdy  = (count != CW'(DEPTH));
  assign ops_val = (count != '0);

  assign push = in_val & in_rdy;
  assign pop  = ops_val & ops_rdy;

`ifdef GCD_OPS_ZERO_DROP_EN
  assign drop = (in_A == '0) && (in_B == '0);
`else
  assign drop = 1'b0;
`endif
  assign store = push & ~drop;

  assign wdata = '{a: in_A, b: in_B};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  gcd_ops_mem #(.W(2*WL), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign ops_A = rdata.a;
  assign ops_B = rdata.b;

endmodule

// File: tb/tb_gcd_ops_fifo.sv
// Directed bench for gcd_ops_fifo: queue model checked every negedge plus literal checkpoints.
module tb_gcd_ops_fifo;
  localparam int WL = 8, DEPTH = 4, CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst_b = 1'b0;
  logic          in_val = 1'b0, ops_rdy = 1'b0;
  logic [WL-1:0] in_A = '0, in_B = '0;
  logic          in_rdy, ops_val;
  logic [WL-1:0] ops_A, ops_B;
  logic [CW-1:0] count;

  int n_tests = 0, n_fail = 0;
  int mqa[$], mqb[$];   // model queue
  int gota[$], gotb[$]; // DUT pairs seen at each pop

  gcd_ops_fifo #(.WL(WL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .in_val(in_val), .in_rdy(in_rdy),
    .in_A(in_A), .in_B(in_B), .ops_val(ops_val), .ops_rdy(ops_rdy),
    .ops_A(ops_A), .ops_B(ops_B), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: plain queue semantics, decided from its own occupancy.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mqa.delete(); mqb.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mqa.size() > 0) && ops_rdy;
      do_push = in_val && (mqa.size() < DEPTH);
`ifdef GCD_OPS_ZERO_DROP_EN
      if (in_A == 0 && in_B == 0) do_push = 0;
`endif
      if (do_pop) begin
        gota.push_back(int'(ops_A)); gotb.push_back(int'(ops_B));
        void'(mqa.pop_front()); void'(mqb.pop_front());
      end
      if (do_push) begin
        mqa.push_back(int'(in_A)); mqb.push_back(int'(in_B));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      chk("count", int'(count), mqa.size());
      chk("ops_val", int'(ops_val), int'(mqa.size() != 0));
      chk("in_rdy", int'(in_rdy), int'(mqa.size() != DEPTH));
      if (mqa.size() != 0) begin
        chk("ops_A", int'(ops_A), mqa[0]);
        chk("ops_B", int'(ops_B), mqb[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push1(int a, int b);
    in_val = 1; in_A = WL'(a); in_B = WL'(b);
    tick();
    in_val = 0;
  endtask

  initial begin
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_ops_val", int'(ops_val), 0);
    chk("rst_in_rdy", int'(in_rdy), 1);
    #10 rst_b = 1;
    tick();

    // single pair
    push1(48, 18);
    chk("sp_count", int'(count), 1);
    chk("sp_A", int'(ops_A), 48);
    chk("sp_B", int'(ops_B), 18);
    ops_rdy = 1; tick(); ops_rdy = 0;
    chk("sp_empty", int'(ops_val), 0);

    // fill and drain
    for (int i = 1; i <= 4; i++) push1(i, i);
    chk("fill_count", int'(count), 4);
    chk("fill_rdy", int'(in_rdy), 0);
    chk("model_full", mqa.size(), 4);
    in_val = 1; in_A = 5; in_B = 5; ops_rdy = 0;
    tick(); in_val = 0;
    chk("fifth_rej", int'(count), 4);
    gota.delete(); gotb.delete();
    ops_rdy = 1; repeat (4) tick(); ops_rdy = 0;
    chk("drain_n", gota.size(), 4);
    for (int i = 0; i < 4 && i < gota.size(); i++) begin
      chk("drain_A", gota[i], i + 1);
      chk("drain_B", gotb[i], i + 1);
    end

    // back-pressure
    push1(21, 14);
    for (int i = 0; i < 5; i++) begin
      chk("bp_A", int'(ops_A), 21);
      chk("bp_B", int'(ops_B), 14);
      chk("bp_count", int'(count), 1);
      tick();
    end
    ops_rdy = 1; tick(); ops_rdy = 0;

    // simultaneous push/pop at count=2, wraps pointers
    gota.delete(); gotb.delete();
    push1(10, 11); push1(12, 13);
    ops_rdy = 1; in_val = 1;
    for (int i = 0; i < 10; i++) begin
      in_A = WL'(20 + i); in_B = WL'(40 + i);
      tick();
      chk("pp_count", int'(count), 2);
    end
    in_val = 0; repeat (2) tick(); ops_rdy = 0;
    chk("pp_n", gota.size(), 12);
    if (gota.size() == 12) begin
      chk("pp_A0", gota[0], 10); chk("pp_B1", gotb[1], 13);
      for (int i = 0; i < 10; i++) begin
        chk("pp_A", gota[i+2], 20 + i);
        chk("pp_B", gotb[i+2], 40 + i);
      end
    end

    // async reset mid-operation
    push1(1, 2); push1(3, 4); push1(5, 6);
    chk("ar_pre", int'(count), 3);
    #2 rst_b = 0; #1;
    chk("ar_count", int'(count), 0);
    chk("ar_val", int'(ops_val), 0);
    chk("ar_rdy", int'(in_rdy), 1);
    in_val = 1; in_A = 7; in_B = 3;
    @(negedge clk); #2 rst_b = 1;
    tick(); in_val = 0;
    chk("ar_first_push", int'(count), 1);
    chk("ar_first_A", int'(ops_A), 7);
    ops_rdy = 1; tick(); ops_rdy = 0;

    // zero pair
    gota.delete(); gotb.delete();
    push1(0, 0); push1(9, 6);
`ifdef GCD_OPS_ZERO_DROP_EN
    chk("zd_count", int'(count), 1);
`else
    chk("zd_count", int'(count), 2);
`endif
    ops_rdy = 1; repeat (2) tick(); ops_rdy = 0;
`ifdef GCD_OPS_ZERO_DROP_EN
    chk("zd_n", gota.size(), 1);
    if (gota.size() > 0) begin chk("zd_A", gota[0], 9); chk("zd_B", gotb[0], 6); end
`else
    chk("zd_n", gota.size(), 2);
    if (gota.size() > 1) begin
      chk("zd_A0", gota[0], 0); chk("zd_A1", gota[1], 9); chk("zd_B1", gotb[1], 6);
    end
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
